// File: rtl/chacha_core_ctrl_pkg.sv
// Shared definitions for the ChaCha block controller: widths, sigma constants,
// FSM state encoding and the quarter-round helper used by the round datapath.
package chacha_core_ctrl_pkg;

  localparam int WORD_W  = 32;
  localparam int COL_W   = 4 * WORD_W;
  localparam int BLOCK_W = 16 * WORD_W;
  localparam int KEY_W   = 8 * WORD_W;
  localparam int NONCE_W = 3 * WORD_W;
  localparam int RCNT_W  = 4;

  localparam logic [WORD_W-1:0] CONST_W0 = 32'h61707865;
  localparam logic [WORD_W-1:0] CONST_W1 = 32'h3320646e;
  localparam logic [WORD_W-1:0] CONST_W2 = 32'h79622d32;
  localparam logic [WORD_W-1:0] CONST_W3 = 32'h6b206574;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_ADD   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
    logic [WORD_W-1:0] c;
    logic [WORD_W-1:0] d;
  } qr_t;

  // ARX quarter round; rotations written as concatenations (16, 12, 8, 7).
  function automatic qr_t quarter_round(input logic [WORD_W-1:0] a_in,
                                        input logic [WORD_W-1:0] b_in,
                                        input logic [WORD_W-1:0] c_in,
                                        input logic [WORD_W-1:0] d_in);
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
    logic [WORD_W-1:0] c;
    logic [WORD_W-1:0] d;
    qr_t               res;
    a = a_in + b_in;  d = d_in ^ a;  d = {d[15:0], d[31:16]};
    c = c_in + d;     b = b_in ^ c;  b = {b[19:0], b[31:20]};
    a = a + b;        d = d ^ a;     d = {d[23:0], d[31:24]};
    c = c + d;        b = b ^ c;     b = {b[24:0], b[31:25]};
    res.a = a;
    res.b = b;
    res.c = c;
    res.d = d;
    return res;
  endfunction

endpackage

// File: rtl/chacha_core_ctrl_round.sv
// Combinational ChaCha double round: four column quarter rounds followed by
// four diagonal quarter rounds; lane i of each column sits at bits [32i+31:32i].
module chacha_core_ctrl_round
  import chacha_core_ctrl_pkg::*;
(
  input  logic [COL_W-1:0] a_i,
  input  logic [COL_W-1:0] b_i,
  input  logic [COL_W-1:0] c_i,
  input  logic [COL_W-1:0] d_i,
  output logic [COL_W-1:0] a_o,
  output logic [COL_W-1:0] b_o,
  output logic [COL_W-1:0] c_o,
  output logic [COL_W-1:0] d_o
);

  logic [COL_W-1:0] col_a_s;
  logic [COL_W-1:0] col_b_s;
  logic [COL_W-1:0] col_c_s;
  logic [COL_W-1:0] col_d_s;

  for (genvar i = 0; i < 4; i++) begin : g_col
    qr_t qr_s;
    assign qr_s = quarter_round(a_i[WORD_W*i +: WORD_W], b_i[WORD_W*i +: WORD_W],
                                c_i[WORD_W*i +: WORD_W], d_i[WORD_W*i +: WORD_W]);
    assign col_a_s[WORD_W*i +: WORD_W] = qr_s.a;
    assign col_b_s[WORD_W*i +: WORD_W] = qr_s.b;
    assign col_c_s[WORD_W*i +: WORD_W] = qr_s.c;
    assign col_d_s[WORD_W*i +: WORD_W] = qr_s.d;
  end

  // Diagonal i takes lane i of a, lane i+1 of b, i+2 of c and i+3 of d (mod 4).
  for (genvar i = 0; i < 4; i++) begin : g_diag
    localparam int JB = (i + 1) % 4;
    localparam int JC = (i + 2) % 4;
    localparam int JD = (i + 3) % 4;
    qr_t qr_s;
    assign qr_s = quarter_round(col_a_s[WORD_W*i +: WORD_W], col_b_s[WORD_W*JB +: WORD_W],
                                col_c_s[WORD_W*JC +: WORD_W], col_d_s[WORD_W*JD +: WORD_W]);
    assign a_o[WORD_W*i  +: WORD_W] = qr_s.a;
    assign b_o[WORD_W*JB +: WORD_W] = qr_s.b;
    assign c_o[WORD_W*JC +: WORD_W] = qr_s.c;
    assign d_o[WORD_W*JD +: WORD_W] = qr_s.d;
  end

endmodule

// File: rtl/chacha_core_ctrl.sv
// ChaCha block controller: loads key/counter/nonce, iterates one double round
// per clock, adds the initial state back in and holds the block until taken.
module chacha_core_ctrl
  import chacha_core_ctrl_pkg::*;
#(
  parameter int NUM_DOUBLE_ROUNDS = 10
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [KEY_W-1:0]   in_key,
  input  logic [WORD_W-1:0]  in_counter,
  input  logic [NONCE_W-1:0] in_nonce,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_block,
  output logic               busy
);

  localparam logic [RCNT_W-1:0] LAST_RND = RCNT_W'(NUM_DOUBLE_ROUNDS - 1);

  state_e              state_q;
  logic [RCNT_W-1:0]   round_cnt_q;
  logic [BLOCK_W-1:0]  work_q;
  logic [BLOCK_W-1:0]  init_q;
  logic [BLOCK_W-1:0]  out_block_q;
  logic                out_valid_q;
  logic                in_ready_q;
  logic                busy_q;

  logic [BLOCK_W-1:0]  init_d;
  logic [BLOCK_W-1:0]  sum_d;
  logic [BLOCK_W-1:0]  round_out_s;

  assign init_d = {in_nonce, in_counter, in_key, CONST_W3, CONST_W2, CONST_W1, CONST_W0};

  for (genvar w = 0; w < 16; w++) begin : g_sum
    assign sum_d[WORD_W*w +: WORD_W] = work_q[WORD_W*w +: WORD_W] + init_q[WORD_W*w +: WORD_W];
  end

  chacha_core_ctrl_round u_round (
    .a_i (work_q[0*COL_W +: COL_W]),
    .b_i (work_q[1*COL_W +: COL_W]),
    .c_i (work_q[2*COL_W +: COL_W]),
    .d_i (work_q[3*COL_W +: COL_W]),
    .a_o (round_out_s[0*COL_W +: COL_W]),
    .b_o (round_out_s[1*COL_W +: COL_W]),
    .c_o (round_out_s[2*COL_W +: COL_W]),
    .d_o (round_out_s[3*COL_W +: COL_W])
  );

  // Control FSM with all outputs registered; out_block only changes in ADD.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      round_cnt_q <= '0;
      work_q      <= '0;
      init_q      <= '0;
      out_block_q <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            work_q      <= init_d;
            init_q      <= init_d;
            round_cnt_q <= '0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          work_q      <= round_out_s;
          round_cnt_q <= round_cnt_q + 4'd1;
          if (round_cnt_q == LAST_RND) begin
            state_q <= ST_ADD;
          end
        end
        ST_ADD: begin
          out_block_q <= sum_d;
          out_valid_q <= 1'b1;
          state_q     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_block = out_block_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_chacha_core_ctrl.sv
// Directed bench for chacha_core_ctrl against RFC 7539 keystream vectors.
module tb_chacha_core_ctrl;

  logic         clock;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] in_key;
  logic [31:0]  in_counter;
  logic [95:0]  in_nonce;
  logic         out_valid;
  logic         out_ready;
  logic [511:0] out_block;
  logic         busy;

  int n_total = 0;
  int n_bad   = 0;

  logic [255:0] key_rfc;
  logic [95:0]  nonce_rfc;

  chacha_core_ctrl #(.NUM_DOUBLE_ROUNDS(10)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_key     (in_key),
    .in_counter (in_counter),
    .in_nonce   (in_nonce),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_block  (out_block),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue one request, optionally scramble inputs while busy, wait for out_valid.
  task automatic run_block(input logic [255:0] k, input logic [31:0] c, input logic [95:0] n,
                           input bit scramble, output logic [511:0] blk, output int lat);
    int w;
    in_key     = k;
    in_counter = c;
    in_nonce   = n;
    w = 0;
    while (!in_ready && w < 40) begin
      tick();
      w++;
    end
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    if (scramble) begin
      in_key     = {8{$urandom()}};
      in_counter = $urandom();
      in_nonce   = {3{$urandom()}};
    end
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    blk = out_block;
  endtask

  initial begin
    logic [511:0] blk;
    logic [511:0] blks [3];
    int           acc_t [3];
    int           lat;
    int           nacc;
    int           nblk;
    int           cyc;
    bit           acc;
    bit           seen_valid;

    for (int k = 0; k < 8; k++) begin
      key_rfc[32*k +: 32] = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
    end
    nonce_rfc = {32'h00000000, 32'h4a000000, 32'h09000000};

    reset      = 1'b1;
    in_valid   = 1'b0;
    in_key     = '0;
    in_counter = '0;
    in_nonce   = '0;
    out_ready  = 1'b0;
    #3;
    check_val("rst_in_ready", 32'(in_ready), 32'd1);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_block_zero", 32'(out_block == 512'd0), 32'd1);
    tick();
    tick();
    reset = 1'b0;

    // RFC 7539 2.3.2 block
    out_ready = 1'b1;
    run_block(key_rfc, 32'd1, nonce_rfc, 1'b0, blk, lat);
    check_val("rfc_latency", 32'(lat), 32'd11);
    check_val("rfc_w0", blk[31:0], 32'he4e7f110);
    check_val("rfc_w15", blk[511:480], 32'h4e3c50a2);
    check_val("done_busy", 32'(busy), 32'd1);
    check_val("done_in_ready", 32'(in_ready), 32'd0);
    tick();
    check_val("idle_out_valid", 32'(out_valid), 32'd0);
    check_val("idle_in_ready", 32'(in_ready), 32'd1);
    check_val("idle_busy", 32'(busy), 32'd0);

    // RFC 7539 A.1 vector #1
    run_block(256'd0, 32'd0, 96'd0, 1'b0, blk, lat);
    check_val("zero_w0", blk[31:0], 32'hade0b876);
    check_val("zero_w1", blk[63:32], 32'h903df1a0);
    tick();

    // Back-pressure: hold out_ready low in DONE
    out_ready = 1'b0;
    run_block(key_rfc, 32'd1, nonce_rfc, 1'b0, blk, lat);
    check_val("bp_latency", 32'(lat), 32'd11);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("bp_valid_hold", 32'(out_valid), 32'd1);
      check_val("bp_w0_hold", out_block[31:0], 32'he4e7f110);
      check_val("bp_w15_hold", out_block[511:480], 32'h4e3c50a2);
      check_val("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    check_val("bp_release_valid", 32'(out_valid), 32'd0);
    check_val("bp_release_ready", 32'(in_ready), 32'd1);

    // Inputs scrambled while busy must not affect the in-flight block
    run_block(key_rfc, 32'd1, nonce_rfc, 1'b1, blk, lat);
    check_val("scr_w0", blk[31:0], 32'he4e7f110);
    check_val("scr_w15", blk[511:480], 32'h4e3c50a2);
    tick();

    // Back-to-back: in_valid held high, counters 1,2,3
    in_key     = key_rfc;
    in_nonce   = nonce_rfc;
    in_counter = 32'd1;
    in_valid   = 1'b1;
    nacc = 0;
    nblk = 0;
    cyc  = 0;
    for (int i = 0; i < 80 && nblk < 3; i++) begin
      acc = in_ready && (nacc < 3);
      if (acc) begin
        acc_t[nacc] = cyc;
        nacc++;
      end
      tick();
      cyc++;
      if (acc) in_counter = in_counter + 32'd1;
      if (out_valid) begin
        blks[nblk] = out_block;
        nblk++;
      end
    end
    in_valid = 1'b0;
    check_val("b2b_accepts", 32'(nacc), 32'd3);
    check_val("b2b_blocks", 32'(nblk), 32'd3);
    check_val("b2b_gap1", 32'(acc_t[1] - acc_t[0]), 32'd13);
    check_val("b2b_gap2", 32'(acc_t[2] - acc_t[1]), 32'd13);
    check_val("b2b_blk0_w0", blks[0][31:0], 32'he4e7f110);
    check_val("b2b_distinct01", 32'(blks[1] != blks[0]), 32'd1);
    check_val("b2b_distinct12", 32'(blks[2] != blks[1]), 32'd1);
    check_val("b2b_distinct02", 32'(blks[2] != blks[0]), 32'd1);
    tick();

    // Reset mid-block at round_cnt=5
    in_key     = key_rfc;
    in_counter = 32'd1;
    in_nonce   = nonce_rfc;
    in_valid   = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    #2;
    reset = 1'b1;
    #1;
    check_val("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check_val("mid_rst_busy", 32'(busy), 32'd0);
    check_val("mid_rst_valid", 32'(out_valid), 32'd0);
    check_val("mid_rst_block", 32'(out_block == 512'd0), 32'd1);
    tick();
    reset = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid) seen_valid = 1'b1;
    end
    check_val("mid_rst_no_valid", 32'(seen_valid), 32'd0);
    run_block(256'd0, 32'd0, 96'd0, 1'b0, blk, lat);
    check_val("post_rst_latency", 32'(lat), 32'd11);
    check_val("post_rst_w0", blk[31:0], 32'hade0b876);
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/chacha_core_ctrl.md
CHACHA_CORE_CTRL -- requirements
Module: chacha_core_ctrl

Interface
REQ-001 SHALL have parameter NUM_DOUBLE_ROUNDS, default 10, the number of double-round iterations per block (legal 1..15).
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  request valid.
REQ-005 SHALL have port in_ready  output  1  controller can accept a request.
REQ-006 SHALL have port in_key  input  256  key; word k (k=0..7) at bits [32k+31:32k].
REQ-007 SHALL have port in_counter  input  32  block counter.
REQ-008 SHALL have port in_nonce  input  96  nonce; word n (n=0..2) at bits [32n+31:32n].
REQ-009 SHALL have port out_valid  output  1  keystream block valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts block.
REQ-011 SHALL have port out_block  output  512  keystream; state word w (w=0..15) at bits [32w+31:32w], no byte swapping.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-013 SHALL build the initial state as words 0-3 = 61707865, 3320646e, 79622d32, 6b206574; words 4-11 = key words 0-7; word 12 = in_counter; words 13-15 = nonce words 0-2.
REQ-014 SHALL map the state to the round datapath as column a = words 0-3, b = words 4-7, c = words 8-11, d = words 12-15, lane i at bits [32i+31:32i] of each 128-bit column.
REQ-015 SHALL use one combinational round instance, one double round (column + diagonal) per clock, with its outputs registered back into the working state.
REQ-016 SHALL implement FSM states IDLE, ROUND, ADD, DONE.
REQ-017 IDLE: in_ready=1; when in_valid is high, SHALL load the working state and the saved initial state, clear round_cnt, and go to ROUND.
REQ-018 ROUND: each cycle SHALL register the round output and increment round_cnt; after the NUM_DOUBLE_ROUNDS-th update SHALL go to ADD.
REQ-019 ADD: SHALL register out_block = working word + initial word, per word, mod 2^32 with the carry discarded, and go to DONE.
REQ-020 DONE: out_valid=1 and out_block SHALL hold stable until out_ready is high, then go to IDLE.
REQ-021 Latency SHALL be: accept edge to out_valid rising = NUM_DOUBLE_ROUNDS+1 cycles (11 at default); accept-to-accept throughput = NUM_DOUBLE_ROUNDS+3 cycles minimum.
REQ-022 in_ready SHALL be 0 in ROUND, ADD and DONE; inputs are ignored outside IDLE, and an in_valid held through DONE is accepted only after the return to IDLE.
REQ-023 In DONE, out_ready and in_valid high together SHALL complete the output handshake only, with no same-cycle accept.
REQ-024 out_ready while out_valid=0 SHALL have no effect.
REQ-025 round_cnt SHALL be 4 bits wide and SHALL NOT wrap within a block.

Reset
REQ-026 reset asserted SHALL immediately force state=IDLE, round_cnt=0, out_valid=0, busy=0, in_ready=1 and out_block=0, clearing the working and initial state registers to 0.
REQ-027 reset asserted mid-block (ROUND/ADD/DONE) SHALL abandon the block, with no out_valid pulse after release.
REQ-028 After reset deasserts, the first rising edge with in_valid=1 SHALL be accepted.

Structure
REQ-029 A shared package SHALL hold the four ChaCha constant words, the FSM state enum, and localparams for word, column and block widths.
REQ-030 The sole sub-module SHALL be the existing combinational round; all other logic is local to chacha_core_ctrl.

Verification
REQ-031 Scenario: key 00010203..1c1d1e1f (byte order per RFC 7539 2.3.2), counter 1, nonce 09000000 4a000000 00000000 -> out_block word0 = e4e7f110, word15 = 4e3c50a2, out_valid exactly 11 cycles after accept.
REQ-032 Scenario: out_ready held low 5 cycles in DONE -> out_valid and out_block stable throughout, in_ready=0, one transfer when out_ready rises.
REQ-033 Scenario: in_valid held high continuously, out_ready=1 -> accepts spaced exactly 13 cycles apart, counter values 1,2,3 producing distinct blocks.
REQ-034 Scenario: reset pulsed at round_cnt=5 -> state IDLE immediately, no out_valid, next request yields the correct block for its own inputs.
REQ-035 Scenario: all-zero key/counter/nonce -> word0 = ade0b876 (RFC 7539 A.1 vector #1).
REQ-036 Scenario: inputs changed while busy=1 -> no effect on the in-flight block result.
